// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_ctrl
// Purpose  : Scan scheduler for a 4-digit multiplexed 7-segment display.
//            Time-slices the digits and blanks the start of each slot to stop
//            ghosting. Applies per-digit masking and leading-zero blanking.
//            Display data is double-buffered and only changes on frame
//            boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
    parameter int SCAN_DIV  = 12500,
    parameter int BLANK_CYC = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  digit_en,
    input  logic        lz_blank,
    output logic [1:0]  sel,
    output logic [3:0]  an,
    output logic [3:0]  digit_val,
    output logic        blank,
    output logic        frame_done
);

    localparam logic [1:0]  c_IDLE       = 2'd0;
    localparam logic [1:0]  c_BLANK      = 2'd1;
    localparam logic [1:0]  c_SHOW       = 2'd2;
    localparam logic [25:0] c_SLOT_LAST  = 26'(SCAN_DIV - 1);
    localparam logic [25:0] c_BLANK_LAST = (BLANK_CYC > 0) ? 26'(BLANK_CYC - 1) : 26'd0;
    // A slot starts in SHOW directly when there is no blank interval.
    localparam logic [1:0]  c_SLOT_START = (BLANK_CYC > 0) ? c_BLANK : c_SHOW;

    logic [1:0]  r_state;
    logic [25:0] r_slot_cnt;
    logic [1:0]  r_sel;
    logic [15:0] r_staging;
    logic [15:0] r_active;
    logic [3:0]  r_an;
    logic [3:0]  r_digit_val;
    logic        r_blank;
    logic        r_frame_done;

    logic [1:0]  w_state;
    logic [25:0] w_slot_cnt;
    logic [1:0]  w_sel;
    logic [15:0] w_staging;
    logic [15:0] w_active;
    logic        w_frame_end;
    logic        w_lz;
    logic        w_visible;
    logic [3:0]  w_an;
    logic [3:0]  w_digit_val;
    logic        w_blank;
    logic        w_frame_done;

    // Next-state, buffer and output decode; outputs are computed from the
    // next state so the registered outputs line up with the state register.
    always_comb begin
        w_state     = r_state;
        w_slot_cnt  = r_slot_cnt;
        w_sel       = r_sel;
        w_staging   = load ? bcd_in : r_staging;
        w_active    = r_active;
        w_frame_end = (r_state == c_SHOW) && (r_sel == 2'd3) && (r_slot_cnt == c_SLOT_LAST);

        if (!en) begin
            w_state    = c_IDLE;
            w_slot_cnt = 26'd0;
            w_sel      = 2'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    w_state    = c_SLOT_START;
                    w_slot_cnt = 26'd0;
                    w_sel      = 2'd0;
                end
                c_BLANK: begin
                    w_slot_cnt = r_slot_cnt + 26'd1;
                    if (r_slot_cnt == c_BLANK_LAST) begin
                        w_state = c_SHOW;
                    end
                end
                c_SHOW: begin
                    if (r_slot_cnt == c_SLOT_LAST) begin
                        w_slot_cnt = 26'd0;
                        w_sel      = r_sel + 2'd1;
                        w_state    = c_SLOT_START;
                    end else begin
                        w_slot_cnt = r_slot_cnt + 26'd1;
                    end
                end
                default: begin
                    w_state    = c_IDLE;
                    w_slot_cnt = 26'd0;
                    w_sel      = 2'd0;
                end
            endcase
        end

        // While stopped the active buffer is written straight through; while
        // scanning it only changes as the digit-3 slot ends (and en is high).
        if ((r_state == c_IDLE) && load) begin
            w_active = bcd_in;
        end else if (en && w_frame_end) begin
            w_active = load ? bcd_in : r_staging;
        end

        // Leading zeros: digit i blanks when it and every higher nibble is 0.
        case (w_sel)
            2'd1:    w_lz = lz_blank && (w_active[15:4] == 12'd0);
            2'd2:    w_lz = lz_blank && (w_active[15:8] == 8'd0);
            2'd3:    w_lz = lz_blank && (w_active[15:12] == 4'd0);
            default: w_lz = 1'b0;
        endcase

        w_visible    = (w_state == c_SHOW) && digit_en[w_sel] && !w_lz;
        w_an         = w_visible ? ~(4'b0001 << w_sel) : 4'b1111;
        w_blank      = !w_visible;
        w_digit_val  = (w_state == c_IDLE) ? 4'd0 : w_active[{w_sel, 2'b00} +: 4];
        w_frame_done = (w_state == c_SHOW) && (w_sel == 2'd3) && (w_slot_cnt == c_SLOT_LAST);
    end

    // State, buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_slot_cnt   <= 26'd0;
            r_sel        <= 2'd0;
            r_staging    <= 16'd0;
            r_active     <= 16'd0;
            r_an         <= 4'b1111;
            r_digit_val  <= 4'd0;
            r_blank      <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_slot_cnt   <= w_slot_cnt;
            r_sel        <= w_sel;
            r_staging    <= w_staging;
            r_active     <= w_active;
            r_an         <= w_an;
            r_digit_val  <= w_digit_val;
            r_blank      <= w_blank;
            r_frame_done <= w_frame_done;
        end
    end

    assign sel        = r_sel;
    assign an         = r_an;
    assign digit_val  = r_digit_val;
    assign blank      = r_blank;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan_ctrl
// Purpose  : Self-checking bench for display_scan_ctrl (SCAN_DIV=8,
//            BLANK_CYC=2): vector table, directed corner sequences and
//            randomized stimulus against a frame-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * SD;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic [1:0]  sel;
    logic [3:0]  an;
    logic [3:0]  digit_val;
    logic        blank;
    logic        frame_done;

    display_scan_ctrl #(
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .bcd_in     (bcd_in),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
        .sel        (sel),
        .an         (an),
        .digit_val  (digit_val),
        .blank      (blank),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cnt_lit  = 0;
    int cnt_d0   = 0;
    int cnt_fd   = 0;

    // Reference model: position within the frame counted from the enable edge.
    bit          m_run = 1'b0;
    int          m_t   = 0;
    logic [15:0] m_stg = 16'd0;
    logic [15:0] m_act = 16'd0;

    task automatic model_step();
        bit was_run;
        bit at_end;
        if (rst) begin
            m_run = 1'b0;
            m_t   = 0;
            m_stg = 16'd0;
            m_act = 16'd0;
        end else begin
            was_run = m_run;
            at_end  = m_run && ((m_t % FRAME) == FRAME - 1);
            if (!was_run && load)  m_act = bcd_in;
            else if (en && at_end) m_act = load ? bcd_in : m_stg;
            if (load) m_stg = bcd_in;
            if (!en) begin
                m_run = 1'b0;
                m_t   = 0;
            end else if (!was_run) begin
                m_run = 1'b1;
                m_t   = 0;
            end else begin
                m_t = m_t + 1;
            end
        end
    endtask

    task automatic model_expect(output logic [1:0] es, output logic [3:0] ea,
                                output logic [3:0] ed, output logic eb, output logic ef);
        int p, d, off;
        bit lz, vis;
        logic [15:0] upper;
        if (!m_run) begin
            es = 2'd0; ea = 4'hF; ed = 4'd0; eb = 1'b1; ef = 1'b0;
        end else begin
            p     = m_t % FRAME;
            d     = p / SD;
            off   = p % SD;
            upper = m_act >> (4 * d);
            lz    = lz_blank && (d > 0) && (upper == 16'd0);
            vis   = (off >= BC) && digit_en[d] && !lz;
            es    = 2'(d);
            ed    = upper[3:0];
            ea    = vis ? ~(4'b0001 << d) : 4'hF;
            eb    = !vis;
            ef    = (p == FRAME - 1);
        end
    endtask

    task automatic check_out(input string nm, input logic [1:0] es, input logic [3:0] ea,
                             input logic [3:0] ed, input logic eb, input logic ef);
        checks++;
        if ({sel, an, digit_val, blank, frame_done} !== {es, ea, ed, eb, ef}) begin
            failures++;
            $display("FAIL %s @%0t: got sel=%0d an=%b dv=%h blank=%b fd=%b, want sel=%0d an=%b dv=%h blank=%b fd=%b",
                     nm, $time, sel, an, digit_val, blank, frame_done, es, ea, ed, eb, ef);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, got, want);
        end
    endtask

    // One clock: advance the model, then compare the DUT with it.
    task automatic tick(input string nm);
        logic [1:0] es;
        logic [3:0] ea, ed;
        logic       eb, ef;
        @(posedge clk);
        model_step();
        #1;
        model_expect(es, ea, ed, eb, ef);
        check_out(nm, es, ea, ed, eb, ef);
        if (an !== 4'hF) cnt_lit++;
        if (an === 4'hE) cnt_d0++;
        if (frame_done === 1'b1) cnt_fd++;
    endtask

    task automatic ticks(input string nm, input int n);
        for (int k = 0; k < n; k++) tick(nm);
    endtask

    task automatic clr_counts();
        cnt_lit = 0;
        cnt_d0  = 0;
        cnt_fd  = 0;
    endtask

    typedef struct {
        logic        r, e, l;
        logic [15:0] bcd;
        logic [3:0]  den;
        logic        lz;
        int          n;
        logic [1:0]  s;
        logic [3:0]  a, dv;
        logic        b, fd;
        string       nm;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic e, input logic l, input logic [15:0] bcd,
                       input int n, input logic [1:0] s, input logic [3:0] a,
                       input logic [3:0] dv, input logic b, input logic fd, input string nm);
        vec_t v;
        v.r = r; v.e = e; v.l = l; v.bcd = bcd; v.den = 4'hF; v.lz = 1'b0; v.n = n;
        v.s = s; v.a = a; v.dv = dv; v.b = b; v.fd = fd; v.nm = nm;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; bcd_in = 16'd0; digit_en = 4'hF; lz_blank = 1'b0;

        // ---- table: reset, idle load, one full frame of 16'h1234 ----
        add(1, 0, 0, 16'h0000, 2, 2'd0, 4'hF, 4'h0, 1, 0, "reset");
        add(0, 0, 1, 16'h1234, 1, 2'd0, 4'hF, 4'h0, 1, 0, "idle_load");
        add(0, 1, 0, 16'h1234, 2, 2'd0, 4'hF, 4'h4, 1, 0, "d0_blank");
        add(0, 1, 0, 16'h1234, 6, 2'd0, 4'hE, 4'h4, 0, 0, "d0_show");
        add(0, 1, 0, 16'h1234, 2, 2'd1, 4'hF, 4'h3, 1, 0, "d1_blank");
        add(0, 1, 0, 16'h1234, 6, 2'd1, 4'hD, 4'h3, 0, 0, "d1_show");
        add(0, 1, 0, 16'h1234, 2, 2'd2, 4'hF, 4'h2, 1, 0, "d2_blank");
        add(0, 1, 0, 16'h1234, 6, 2'd2, 4'hB, 4'h2, 0, 0, "d2_show");
        add(0, 1, 0, 16'h1234, 2, 2'd3, 4'hF, 4'h1, 1, 0, "d3_blank");
        add(0, 1, 0, 16'h1234, 5, 2'd3, 4'h7, 4'h1, 0, 0, "d3_show");
        add(0, 1, 0, 16'h1234, 1, 2'd3, 4'h7, 4'h1, 0, 1, "frame_done");
        add(0, 1, 0, 16'h1234, 2, 2'd0, 4'hF, 4'h4, 1, 0, "f2_d0_blank");
        add(0, 1, 0, 16'h1234, 6, 2'd0, 4'hE, 4'h4, 0, 0, "f2_d0_show");
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r; en = tbl[i].e; load = tbl[i].l; bcd_in = tbl[i].bcd;
            digit_en = tbl[i].den; lz_blank = tbl[i].lz;
            for (int k = 0; k < tbl[i].n; k++) begin
                @(posedge clk);
                model_step();
                #1;
                check_out(tbl[i].nm, tbl[i].s, tbl[i].a, tbl[i].dv, tbl[i].b, tbl[i].fd);
            end
        end

        // ---- leading-zero blanking ----
        en = 1'b0; tick("lz_stop");
        load = 1'b1; bcd_in = 16'h0040; tick("lz_load");
        load = 1'b0; lz_blank = 1'b1; en = 1'b1;
        clr_counts(); ticks("lz_0040", FRAME);
        check_int("lz_0040_lit", cnt_lit, 12);
        check_int("lz_0040_fd", cnt_fd, 1);
        load = 1'b1; bcd_in = 16'h0000; tick("lz_stage0");
        load = 1'b0; ticks("lz_wait", FRAME - 1);
        clr_counts(); ticks("lz_0000", FRAME);
        check_int("lz_0000_lit", cnt_lit, 6);
        check_int("lz_0000_d0", cnt_d0, 6);

        // ---- double buffering ----
        lz_blank = 1'b0; en = 1'b0; tick("buf_stop");
        load = 1'b1; bcd_in = 16'h1234; tick("buf_load");
        load = 1'b0; en = 1'b1;
        ticks("buf_to_d1", 12);                       // frame position 11
        load = 1'b1; bcd_in = 16'h5678; tick("buf_mid_load");
        load = 1'b0; ticks("buf_old", 18);            // position 30
        check_int("buf_old_d3", int'(digit_val), 1);
        ticks("buf_fd", 3);                           // position 33
        check_int("buf_new_d0", int'(digit_val), 8);
        ticks("buf_run", 30);                         // position 63
        check_int("buf_fd_cycle", int'(frame_done), 1);
        load = 1'b1; bcd_in = 16'h9A0C; tick("buf_fd_load");
        load = 1'b0;
        check_int("buf_fd_load_d0", int'(digit_val), 12);
        ticks("buf_to_d2", 18);                       // digit 2, show cycle
        check_int("buf_passthru_A", int'(digit_val), 10);
        check_int("buf_d2_an", int'(an), 4'hB);

        // ---- digit mask ----
        digit_en = 4'b0101;
        ticks("mask_align", 13);
        clr_counts(); ticks("mask", 2 * FRAME);
        check_int("mask_lit", cnt_lit, 24);
        check_int("mask_fd", cnt_fd, 2);
        digit_en = 4'hF;

        // ---- en drop mid-slot and restart ----
        ticks("drop_align", 21);                      // digit 2, 3rd show cycle
        en = 1'b0; tick("drop");
        check_out("drop_idle", 2'd0, 4'hF, 4'h0, 1'b1, 1'b0);
        en = 1'b1; tick("restart");
        check_out("restart_b0", 2'd0, 4'hF, 4'hC, 1'b1, 1'b0);
        tick("restart");
        check_out("restart_b1", 2'd0, 4'hF, 4'hC, 1'b1, 1'b0);
        tick("restart");
        check_out("restart_show", 2'd0, 4'hE, 4'hC, 1'b0, 1'b0);

        // ---- en drop on the frame-end cycle: no active update ----
        ticks("fe_align", 29);                        // position 31
        en = 1'b0; load = 1'b1; bcd_in = 16'h1111; tick("fe_drop");
        check_out("fe_drop_idle", 2'd0, 4'hF, 4'h0, 1'b1, 1'b0);
        load = 1'b0; tick("fe_idle");
        en = 1'b1; tick("fe_restart");
        check_int("fe_active_kept", int'(digit_val), 12);
        ticks("fe_run", FRAME);
        check_int("fe_staged_applied", int'(digit_val), 1);

        // ---- synchronous reset mid-slot ----
        ticks("rst_align", 11);
        rst = 1'b1; tick("rst");
        check_out("rst_values", 2'd0, 4'hF, 4'h0, 1'b1, 1'b0);
        rst = 1'b0; lz_blank = 1'b1;
        clr_counts(); ticks("rst_after", FRAME);
        check_int("rst_lit", cnt_lit, 6);
        check_int("rst_d0", cnt_d0, 6);

        // ---- randomized ----
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            en   = ($urandom_range(0, 49) != 0);
            load = ($urandom_range(0, 9) == 0);
            bcd_in = 16'($urandom);
            if ($urandom_range(0, 5) == 0) bcd_in = 16'(bcd_in & 16'h00FF);
            if ($urandom_range(0, 63) == 0) digit_en = 4'($urandom);
            if ($urandom_range(0, 63) == 0) lz_blank = 1'($urandom);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
